// File: rtl/rx_frame_check.sv
// rx_frame_check: serial frame checker behind a UART start-bit detector.
// Assembles LSB-first data bits, checks an optional parity bit and one or two
// stop bits, and pulses data_valid with the decoded word and error flags.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   frame_start       start bit validated; (re)starts a frame, latches config
//   bit_valid         sampled_bit carries the next serial bit
//   sampled_bit       majority-sampled serial bit
//   parity_en         frame carries a parity bit
//   parity_type       0 = even, 1 = odd
//   stop2             two stop bits when set, one otherwise
//   cnt_clr           synchronous clear of both error counters
//   P_DATA            assembled data word of the last completed frame
//   data_valid        one-cycle pulse after the last stop bit
//   par_err, stp_err  error flags of the last completed frame
//   busy              a frame is in progress
//   par_err_cnt,
//   stp_err_cnt       saturating error counters
//
// Configuration macro: RX_FRAME_CHECK_ERR_CNT_EN enables the error counters;
// when undefined the counter ports are tied to zero and cnt_clr is ignored.

module rx_frame_check #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  parity_en,
    input  logic                  parity_type,
    input  logic                  stop2,
    input  logic                  cnt_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_type_q, par_type_nxt;
    logic                  stop2_q, stop2_nxt;
    logic                  stop_cnt, stop_cnt_nxt;
    logic [DATA_WIDTH-1:0] p_data_nxt;
    logic                  data_valid_nxt;
    logic                  par_err_nxt;
    logic                  stp_err_nxt;
    logic                  busy_nxt;

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            par_en_q   <= par_en_nxt;
            par_type_q <= par_type_nxt;
            stop2_q    <= stop2_nxt;
            stop_cnt   <= stop_cnt_nxt;
            P_DATA     <= p_data_nxt;
            data_valid <= data_valid_nxt;
            par_err    <= par_err_nxt;
            stp_err    <= stp_err_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and output logic; frame_start overrides any bit in the same cycle
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        par_en_nxt     = par_en_q;
        par_type_nxt   = par_type_q;
        stop2_nxt      = stop2_q;
        stop_cnt_nxt   = stop_cnt;
        p_data_nxt     = P_DATA;
        data_valid_nxt = 1'b0;
        par_err_nxt    = par_err;
        stp_err_nxt    = stp_err;

        if (frame_start) begin
            state_nxt    = DATA;
            bit_cnt_nxt  = '0;
            shreg_nxt    = '0;
            par_en_nxt   = parity_en;
            par_type_nxt = parity_type;
            stop2_nxt    = stop2;
            stop_cnt_nxt = 1'b0;
            par_err_nxt  = 1'b0;
            stp_err_nxt  = 1'b0;
        end else if (bit_valid) begin
            case (state)
                DATA: begin
                    shreg_nxt = {sampled_bit, shreg[DATA_WIDTH-1:1]};
                    if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BCW'(1);
                    end
                end
                PARITY: begin
                    // Received bit must equal data parity folded with the parity type
                    par_err_nxt = sampled_bit ^ (^shreg) ^ par_type_q;
                    state_nxt   = STOP;
                end
                STOP: begin
                    if (!sampled_bit) begin
                        stp_err_nxt = 1'b1;
                    end
                    // stop_cnt indexes the stop bit; the last one is index stop2_q
                    if (stop_cnt == stop2_q) begin
                        state_nxt      = IDLE;
                        stop_cnt_nxt   = 1'b0;
                        data_valid_nxt = 1'b1;
                        p_data_nxt     = shreg;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

`ifdef RX_FRAME_CHECK_ERR_CNT_EN
    // Saturating error counters, bumped while data_valid reports a flagged frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (cnt_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
        end else if (data_valid) begin
            if (par_err && (par_err_cnt != '1)) begin
                par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
            end
            if (stp_err && (stp_err_cnt != '1)) begin
                stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign par_err_cnt    = '0;
    assign stp_err_cnt    = '0;
`endif

endmodule
